mux_scan_reg: RTL and testbench
===============================

Name: mux_scan_reg

Overview:
- Parametrised CH-channel, W-bit-wide registered multiplexer. It is the successor to the single-bit 2/4/8/16-to-1 mux tree.
- Two modes:
  - Manual: an explicit select is loaded.
  - Scan: an internal round-robin pointer steps through the enabled channels.
- The result is presented through a registered valid/ready output stage.
- It sits between parallel sample sources and a single serial consumer (display driver, UART formatter).

Parameters:
- CH, 16, channel count; a power of 2, at least 2.
- W, 8, bits per channel.
- SELW, $clog2(CH), select/pointer width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- x  input  CH*W  channel data, ascending indexing [0:CH*W-1]; channel i occupies x[i*W : i*W+W-1], so channel 0 is leftmost.
- mode  input  1  0 = manual, 1 = scan.
- s  input  SELW  manual channel select, ascending [0:SELW-1], s[0] = MSB.
- load  input  1  manual-mode capture request.
- en  input  CH  scan-mode channel enable mask; en[i] gates channel i.
- ready  input  1  consumer accepts f this cycle.
- f  output  W  registered selected data.
- fsel  output  SELW  channel index that f came from.
- valid  output  1  f/fsel hold a transfer.

Behaviour:
- Reset: when rst_n=0 at a clock edge, f=0, fsel=0, valid=0, ptr=0. The reset overrides all other inputs in that cycle.
- Output slot is free when (!valid || ready). The output registers update only on a free-slot edge.
- Stall: if valid=1 and ready=0, f, fsel and valid hold exactly and ptr does not move.
- Transfer: a transfer completes on any edge with valid=1 and ready=1.
- Manual mode (mode=0):
  - On a free-slot edge with load=1: f <= channel[s], fsel <= s, valid <= 1. Latency is 1 cycle from load to valid.
  - On a free-slot edge with load=0: valid <= 0; f and fsel hold.
  - ptr is unaffected.
- Scan mode (mode=1), two states:
  - SCAN_IDLE: en all zero. On a free slot, valid <= 0 and ptr holds.
  - SCAN_RUN: at least one en bit set. On a free slot, pick c = first index >= ptr with en[c]=1, searching cyclically with wrap CH-1 -> 0. Then f <= channel[c], fsel <= c, valid <= 1, ptr <= (c+1) mod CH.
  - A single enabled channel is emitted on every free cycle.
  - ptr = CH-1 wraps to 0.
  - The state is selected combinationally from en on every cycle.
- Data and mask sampling: x and en are sampled on the capture edge only. Changing x while stalled does not alter f.
- Mode change: takes effect at the next free-slot edge. An in-flight stalled transfer always completes unchanged. ptr is retained across mode changes and cleared only by reset.
- Ignored inputs: load and s are ignored in scan mode; en is ignored in manual mode.
- Back-to-back throughput: with ready held at 1, the block delivers one transfer per cycle in both modes.
- Reset mid-stall: valid drops to 0 on that edge and the pending word is discarded.

Decomposition:
- Shared include `mux_defs.vh`:
  - MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
  - A clog2 function for SELW.
- Sub-module `mux_wide`: combinational parametrised CH-to-1, W-bit mux, built as a generate tree of 2:1 stages. It is instantiated once and driven by either s or the round-robin pick c.
- The round-robin finder and output registers stay in the top module.

Test Plan:
CH=4, W=8, x = 11,22,33,44 (hex, channels 0..3) throughout.
- Reset: hold rst_n=0 for 2 cycles with load=1 -> f=00, fsel=0, valid=0. Release; first valid appears 1 cycle after the first load edge.
- Manual: mode=0, s=2, load=1, ready=1 -> next cycle f=33, fsel=2, valid=1. Drop load -> valid=0 the following cycle.
- Manual stall: s=1 loaded, ready=0 for 3 cycles while s=3 and x changes -> f stays 22, fsel 1. Raise ready -> next word is 44.
- Scan with mask: mode=1, en=1011 (channels 0,2,3), ready=1 -> fsel sequence 0,2,3,0,2. f sequence 11,33,44,11,33.
- Scan boundaries:
  - en=0001 -> fsel=3 every cycle.
  - en=0000 -> valid=0 and ptr held.
  - Re-enabling en=1111 from ptr=0 -> fsel 0,1,2,3,0.
- Mode switch under stall: scan word fsel=2 pending with ready=0, then mode->0 with s=0, load=1. Raise ready -> fsel=2 transfers first, then f=11, fsel=0.

Source files
------------

// File: rtl/mux_scan_reg_pkg.sv
// Shared definitions for the registered channel multiplexer: mode encodings,
// scan-state type and the select-width helper.
package mux_scan_reg_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

  // Ceiling log2; callers guarantee value >= 2 so the result is at least 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_reg_wide.sv
// Combinational CH-to-1, W-bit multiplexer built as a tree of 2:1 stages;
// stage lv consumes select bit lv, so the leaf stage pairs channels 2k/2k+1.
module mux_wide
  import mux_scan_reg_pkg::*;
#(
  parameter int CH   = 16,
  parameter int W    = 8,
  parameter int SELW = clog2(CH)
) (
  input  logic [W-1:0]    din [CH],
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    dout
);

  for (genvar lv = 0; lv < SELW; lv++) begin : g_stage
    localparam int N = CH >> (lv + 1);
    logic [W-1:0] node [N];
    for (genvar k = 0; k < N; k++) begin : g_node
      if (lv == 0) begin : g_leaf
        assign node[k] = sel[lv] ? din[2*k+1] : din[2*k];
      end else begin : g_inner
        assign node[k] = sel[lv] ? g_stage[lv-1].node[2*k+1]
                                 : g_stage[lv-1].node[2*k];
      end
    end
  end

  assign dout = g_stage[SELW-1].node[0];

endmodule

// File: rtl/mux_scan_reg.sv
// Registered CH-channel multiplexer with manual select and round-robin scan
// modes, presented through a valid/ready output register.
module mux_scan_reg
  import mux_scan_reg_pkg::*;
#(
  parameter  int CH   = 16,
  parameter  int W    = 8,
  localparam int SELW = clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [0:CH*W-1]     x,
  input  logic                mode,
  input  logic [0:SELW-1]     s,
  input  logic                load,
  input  logic [0:CH-1]       en,
  input  logic                ready,
  output logic [W-1:0]        f,
  output logic [SELW-1:0]     fsel,
  output logic                valid
);

  logic [W-1:0]    f_q, f_d;
  logic [SELW-1:0] fsel_q, fsel_d;
  logic            valid_q, valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [W-1:0]    din [CH];
  logic [SELW-1:0] s_val;
  logic [SELW-1:0] pick;
  logic [SELW-1:0] mux_sel;
  logic [W-1:0]    mux_out;
  logic            slot_free;
  scan_state_e     scan_state;

  // Channel 0 sits in the leftmost W bits of the ascending-indexed bus.
  for (genvar i = 0; i < CH; i++) begin : g_chan
    assign din[i] = x[i*W +: W];
  end

  assign s_val      = s;
  assign slot_free  = !valid_q || ready;
  assign scan_state = (|en) ? SCAN_RUN : SCAN_IDLE;

  // First enabled channel at or after ptr, wrapping through CH-1 -> 0.
  always_comb begin
    logic            found;
    logic [SELW-1:0] idx;
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CH; k++) begin
      idx = ptr_q + SELW'(k);
      if (!found && en[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign mux_sel = (mode == MODE_MANUAL) ? s_val : pick;

  mux_wide #(
    .CH   (CH),
    .W    (W),
    .SELW (SELW)
  ) u_mux (
    .din  (din),
    .sel  (mux_sel),
    .dout (mux_out)
  );

  always_comb begin
    f_d     = f_q;
    fsel_d  = fsel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (slot_free) begin
      if (mode == MODE_MANUAL) begin
        if (load) begin
          f_d     = mux_out;
          fsel_d  = s_val;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end else begin
        unique case (scan_state)
          SCAN_RUN: begin
            f_d     = mux_out;
            fsel_d  = pick;
            valid_d = 1'b1;
            ptr_d   = pick + SELW'(1);
          end
          default: begin
            valid_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q     <= '0;
      fsel_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      f_q     <= f_d;
      fsel_q  <= fsel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign f     = f_q;
  assign fsel  = fsel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg at CH=4, W=8 with channels 11,22,33,44.
module tb_mux_scan_reg;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam logic [0:31] X_BASE = 32'h11223344;

  logic          clk;
  logic          rst_n;
  logic [0:31]   x;
  logic          mode;
  logic [0:1]    s;
  logic          load;
  logic [0:3]    en;
  logic          ready;
  logic [7:0]    f;
  logic [1:0]    fsel;
  logic          valid;

  int vectors;
  int miscompares;

  logic [7:0] exp_f [5];
  logic [1:0] exp_s [5];

  mux_scan_reg #(
    .CH (CH),
    .W  (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .mode  (mode),
    .s     (s),
    .load  (load),
    .en    (en),
    .ready (ready),
    .f     (f),
    .fsel  (fsel),
    .valid (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x = X_BASE; mode = 1'b0; s = 2'd2; load = 1'b1;
    en = 4'b0000; ready = 1'b1;
    step();
    step();
    vectors++;
    if (f !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_f: got %h expected 00", f); end
    vectors++;
    if (fsel !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_fsel: got %0d expected 0", fsel); end
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    rst_n = 1'b1;
    step();
    vectors++;
    if (valid !== 1'b1 || f !== 8'h33 || fsel !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL reset_first_load: got v=%b f=%h sel=%0d expected v=1 f=33 sel=2", valid, f, fsel);
    end
  endtask

  task automatic test_manual();
    mode = 1'b0; s = 2'd2; load = 1'b1; ready = 1'b1;
    step();
    vectors++;
    if (valid !== 1'b1 || f !== 8'h33 || fsel !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL manual_load: got v=%b f=%h sel=%0d expected v=1 f=33 sel=2", valid, f, fsel);
    end
    load = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b0 || f !== 8'h33 || fsel !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL manual_drop: got v=%b f=%h sel=%0d expected v=0 f=33 sel=2", valid, f, fsel);
    end
  endtask

  task automatic test_manual_stall();
    s = 2'd1; load = 1'b1; ready = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b1 || f !== 8'h22 || fsel !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL stall_capture: got v=%b f=%h sel=%0d expected v=1 f=22 sel=1", valid, f, fsel);
    end
    s = 2'd3; x = 32'hAABBCCDD;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || f !== 8'h22 || fsel !== 2'd1) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b f=%h sel=%0d expected v=1 f=22 sel=1", i, valid, f, fsel);
      end
      x = ~x;
    end
    x = X_BASE; ready = 1'b1;
    step();
    vectors++;
    if (valid !== 1'b1 || f !== 8'h44 || fsel !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got v=%b f=%h sel=%0d expected v=1 f=44 sel=3", valid, f, fsel);
    end
    load = 1'b0;
    step();
  endtask

  task automatic test_scan_mask();
    mode = 1'b1; en = 4'b1011; ready = 1'b1; s = 2'd1; load = 1'b1;
    exp_s = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    exp_f = '{8'h11, 8'h33, 8'h44, 8'h11, 8'h33};
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || f !== exp_f[i] || fsel !== exp_s[i]) begin
        miscompares++;
        $display("[TB] FAIL scan_mask[%0d]: got v=%b f=%h sel=%0d expected v=1 f=%h sel=%0d",
                 i, valid, f, fsel, exp_f[i], exp_s[i]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_scan_boundaries();
    en = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || f !== 8'h44 || fsel !== 2'd3) begin
        miscompares++;
        $display("[TB] FAIL scan_single[%0d]: got v=%b f=%h sel=%0d expected v=1 f=44 sel=3", i, valid, f, fsel);
      end
    end
    en = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (valid !== 1'b0 || f !== 8'h44 || fsel !== 2'd3) begin
        miscompares++;
        $display("[TB] FAIL scan_idle[%0d]: got v=%b f=%h sel=%0d expected v=0 f=44 sel=3", i, valid, f, fsel);
      end
    end
    en = 4'b1111;
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_f = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || f !== exp_f[i] || fsel !== exp_s[i]) begin
        miscompares++;
        $display("[TB] FAIL scan_all[%0d]: got v=%b f=%h sel=%0d expected v=1 f=%h sel=%0d",
                 i, valid, f, fsel, exp_f[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_mode_switch_stall();
    en = 4'b0010; ready = 1'b1;
    step();
    vectors++;
    if (valid !== 1'b1 || f !== 8'h33 || fsel !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL switch_pending: got v=%b f=%h sel=%0d expected v=1 f=33 sel=2", valid, f, fsel);
    end
    ready = 1'b0; mode = 1'b0; s = 2'd0; load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || f !== 8'h33 || fsel !== 2'd2) begin
        miscompares++;
        $display("[TB] FAIL switch_stall[%0d]: got v=%b f=%h sel=%0d expected v=1 f=33 sel=2", i, valid, f, fsel);
      end
    end
    ready = 1'b1;
    step();
    vectors++;
    if (valid !== 1'b1 || f !== 8'h11 || fsel !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL switch_manual: got v=%b f=%h sel=%0d expected v=1 f=11 sel=0", valid, f, fsel);
    end
    load = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; ready = 1'b1; load = 1'b1;
    exp_f = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h22};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 5; i++) begin
      s = exp_s[i];
      step();
      vectors++;
      if (valid !== 1'b1 || f !== exp_f[i] || fsel !== exp_s[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b[%0d]: got v=%b f=%h sel=%0d expected v=1 f=%h sel=%0d",
                 i, valid, f, fsel, exp_f[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    s = 2'd3; load = 1'b1; ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b0 || f !== 8'h00 || fsel !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_stall: got v=%b f=%h sel=%0d expected v=0 f=00 sel=0", valid, f, fsel);
    end
    rst_n = 1'b1; mode = 1'b1; en = 4'b1111; ready = 1'b1; load = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b1 || f !== 8'h11 || fsel !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ptr: got v=%b f=%h sel=%0d expected v=1 f=11 sel=0", valid, f, fsel);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_manual();
    test_manual_stall();
    test_scan_mask();
    test_scan_boundaries();
    test_mode_switch_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
